input_conditioner: RTL
======================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 3: consecutive equal tick samples before a debounced level changes.
REQ-002 Parameter HOLD_TICKS, default 8: ticks a latched turn request stays pending if not consumed.
REQ-003 Parameter MIC_HI, default 8'h40: bongo mic level that asserts the mic u-turn.
REQ-004 Parameter MIC_LO, default 8'h30: bongo mic release level, used only with hysteresis.
REQ-005 clk  in  1  single clock for the block; all state updates on its rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 tick  in  1  one-cycle game-tick enable; all sampling and counting occurs only on cycles with tick=1.
REQ-008 ctrl_select  in  1  source select: 1 = bongo, 0 = NES.
REQ-009 ctrl_mode  in  1  mapping mode: 1 = direction, 0 = rotation.
REQ-010 pacman_dir  in  2  current Pac-Man heading: RT=00, UP=01, DN=10, LT=11.
REQ-011 nes_btns  in  [0:7]  raw NES buttons.
REQ-012 bongo_btns  in  [0:15]  raw bongo buttons.
REQ-013 bongo_mic  in  8  bongo mic level.
REQ-014 consume  in  1  game controller accepted the pending turn this cycle.
REQ-015 start_pulse  out  1  one-cycle pulse on a debounced start press.
REQ-016 lturn / rturn / uturn  out  1 each  pending turn request, one-hot or all zero.
REQ-017 req_valid  out  1  a turn request is pending; equals lturn|rturn|uturn.

Function
REQ-018 Start source SHALL be nes_btns[3] or bongo_btns[3], chosen by ctrl_select.
REQ-019 Rotation mode, NES: l=nes[1], r=nes[0], u=nes[5].
REQ-020 Rotation mode, bongo: l=bongo[4]|bongo[6], r=bongo[5]|bongo[7], u=mic_active and not (l or r).
REQ-021 Direction mode, NES (l,r,u) by pacman_dir: RT(4,5,6), UP(6,7,5), DN(7,6,4), LT(5,4,7).
REQ-022 Direction mode, bongo (l,r,u) by pacman_dir: RT(12,13,15), UP(15,14,13), DN(14,15,12), LT(13,12,14).
REQ-023 Each of start/l/r/u SHALL be debounced per REQ-001; the debounced level changes on the tick completing DEBOUNCE_CNT equal samples.
REQ-024 Only a debounced rising edge SHALL create a request; level hold SHALL NOT re-trigger.
REQ-025 Simultaneous rising edges: priority l > r > u.
REQ-026 FSM IDLE -> PEND on a request edge: latch the one-hot request and load hold counter = HOLD_TICKS.
REQ-027 In PEND, the hold counter decrements on each tick.
REQ-028 In PEND, consume=1 -> IDLE the next cycle.
REQ-029 In PEND, counter reaching 0 -> IDLE (request expires).
REQ-030 In PEND, a new request edge replaces the latched request and reloads the counter; a new edge wins over consume in the same cycle.
REQ-031 start_pulse SHALL assert on the cycle after the debounced start rising edge, for exactly one cycle; it is independent of the FSM.
REQ-032 A change of ctrl_select or ctrl_mode SHALL clear debouncers and pending state to IDLE on the next cycle; no edge is generated by the switch itself.
REQ-033 Output latency: a request is visible one cycle after the tick that completes its debounce.

Reset
REQ-034 On rst=1: FSM in IDLE; all outputs 0; debounced levels 0; counters 0; mic_active 0.
REQ-035 rst mid-PEND SHALL drop the pending request immediately; rst has priority over all other inputs.

Configuration
REQ-036 INPUT_MIC_HYST_EN defined: mic_active sets when bongo_mic > MIC_HI and clears when bongo_mic < MIC_LO, evaluated on tick.
REQ-037 INPUT_MIC_HYST_EN undefined: mic_active = (bongo_mic > MIC_HI), combinational; MIC_LO is unused.

Structure
REQ-038 Package pacman_input_pkg: direction codes RT/UP/DN/LT; NES and bongo direction-mode index tables; FSM state enum; parameter defaults.
REQ-039 Sub-module btn_debounce: one instance per signal (start, l, r, u), with outputs level and rise.

Verification
REQ-040 NES rotation, nes[1] held 3 ticks -> lturn=1 and req_valid=1 one cycle later; consume -> all 0 the next cycle.
REQ-041 nes[0] held 2 ticks then released (glitch) -> no request, outputs stay 0.
REQ-042 Direction mode, pacman_dir=UP, nes[7] pressed -> rturn; no consume -> cleared after 8 ticks.
REQ-043 Bongo, mic 8'h50 then 8'h38: with INPUT_MIC_HYST_EN, uturn once and mic_active stays 1; without it, mic_active drops.
REQ-044 l and r rising on the same tick -> lturn only; rst during PEND -> all outputs 0 the next cycle.
REQ-045 ctrl_select toggled while PEND -> IDLE the next cycle and start_pulse stays 0.

Source files
------------

// File: rtl/pacman_input_pkg.sv
// Shared types, defaults and direction-mode button maps for the Pac-Man input conditioner.
package pacman_input_pkg;

    typedef enum logic [1:0] {
        DIR_RT = 2'b00,
        DIR_UP = 2'b01,
        DIR_DN = 2'b10,
        DIR_LT = 2'b11
    } dir_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } turn_state_e;

    localparam int          DEBOUNCE_CNT_DEF = 3;
    localparam int          HOLD_TICKS_DEF   = 8;
    localparam logic [7:0]  MIC_HI_DEF       = 8'h40;
    localparam logic [7:0]  MIC_LO_DEF       = 8'h30;

    typedef struct packed {
        logic [2:0] l;
        logic [2:0] r;
        logic [2:0] u;
    } nes_map_t;

    typedef struct packed {
        logic [3:0] l;
        logic [3:0] r;
        logic [3:0] u;
    } bongo_map_t;

    // Button indices for left/right/u-turn relative to the current heading.
    function automatic nes_map_t nes_dir_map(input dir_e d);
        case (d)
            DIR_RT:  return '{l: 3'd4, r: 3'd5, u: 3'd6};
            DIR_UP:  return '{l: 3'd6, r: 3'd7, u: 3'd5};
            DIR_DN:  return '{l: 3'd7, r: 3'd6, u: 3'd4};
            default: return '{l: 3'd5, r: 3'd4, u: 3'd7};
        endcase
    endfunction

    function automatic bongo_map_t bongo_dir_map(input dir_e d);
        case (d)
            DIR_RT:  return '{l: 4'd12, r: 4'd13, u: 4'd15};
            DIR_UP:  return '{l: 4'd15, r: 4'd14, u: 4'd13};
            DIR_DN:  return '{l: 4'd14, r: 4'd15, u: 4'd12};
            default: return '{l: 4'd13, r: 4'd12, u: 4'd14};
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Tick-sampled debouncer: level follows the input after DEBOUNCE_CNT equal samples,
// rise flags (combinationally) the tick on which the level goes 0 -> 1.
module btn_debounce #(
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_clr,
    input  logic i_din,
    output logic o_level,
    output logic o_rise
);

    localparam int            CW   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_done;

    assign w_differ = (i_din != r_level);
    assign w_done   = i_tick && w_differ && (r_cnt == LAST);

    // r_cnt counts consecutive samples that disagree with the current level.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (i_tick) begin
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= i_din;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = w_done && i_din && !i_clr;

endmodule

// File: rtl/input_conditioner.sv
// Maps NES/bongo buttons to debounced start pulses and held turn requests.
// Optional build macro INPUT_MIC_HYST_EN: tick-sampled mic hysteresis between MIC_LO and MIC_HI.
module input_conditioner
    import pacman_input_pkg::*;
#(
    parameter int         DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int         HOLD_TICKS   = HOLD_TICKS_DEF,
    parameter logic [7:0] MIC_HI       = MIC_HI_DEF,
    parameter logic [7:0] MIC_LO       = MIC_LO_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        ctrl_select,
    input  logic        ctrl_mode,
    input  logic [1:0]  pacman_dir,
    input  logic [7:0]  nes_btns,
    input  logic [15:0] bongo_btns,
    input  logic [7:0]  bongo_mic,
    input  logic        consume,
    output logic        start_pulse,
    output logic        lturn,
    output logic        rturn,
    output logic        uturn,
    output logic        req_valid
);

    localparam int            HW        = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

    if (MIC_LO > MIC_HI) begin : g_mic_cfg_check
        $error("input_conditioner: MIC_LO must not exceed MIC_HI");
    end

    logic r_sel;
    logic r_mode;
    logic w_switch;

    // A source/mode change restarts all debouncing and drops any pending turn.
    always_ff @(posedge clk) begin
        r_sel  <= ctrl_select;
        r_mode <= ctrl_mode;
    end
    assign w_switch = (ctrl_select != r_sel) || (ctrl_mode != r_mode);

    logic w_mic_active;
`ifdef INPUT_MIC_HYST_EN
    logic r_mic_active;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mic_active <= 1'b0;
        end else if (tick) begin
            if (bongo_mic > MIC_HI) begin
                r_mic_active <= 1'b1;
            end else if (bongo_mic < MIC_LO) begin
                r_mic_active <= 1'b0;
            end
        end
    end
    assign w_mic_active = r_mic_active;
`else
    assign w_mic_active = (bongo_mic > MIC_HI);
`endif

    nes_map_t   w_nmap;
    bongo_map_t w_bmap;
    logic       w_start_raw;
    logic       w_l_raw;
    logic       w_r_raw;
    logic       w_u_raw;

    assign w_nmap = nes_dir_map(dir_e'(pacman_dir));
    assign w_bmap = bongo_dir_map(dir_e'(pacman_dir));

    always_comb begin
        w_start_raw = ctrl_select ? bongo_btns[3] : nes_btns[3];
        w_l_raw     = 1'b0;
        w_r_raw     = 1'b0;
        w_u_raw     = 1'b0;
        if (ctrl_select) begin
            if (ctrl_mode) begin
                w_l_raw = bongo_btns[w_bmap.l];
                w_r_raw = bongo_btns[w_bmap.r];
                w_u_raw = bongo_btns[w_bmap.u];
            end else begin
                w_l_raw = bongo_btns[4] | bongo_btns[6];
                w_r_raw = bongo_btns[5] | bongo_btns[7];
                w_u_raw = w_mic_active & ~(w_l_raw | w_r_raw);
            end
        end else begin
            if (ctrl_mode) begin
                w_l_raw = nes_btns[w_nmap.l];
                w_r_raw = nes_btns[w_nmap.r];
                w_u_raw = nes_btns[w_nmap.u];
            end else begin
                w_l_raw = nes_btns[1];
                w_r_raw = nes_btns[0];
                w_u_raw = nes_btns[5];
            end
        end
    end

    // Debounced levels are exposed for debug taps; only the rise strobes drive logic here.
    logic [3:0] w_levels_unused;
    logic       w_start_rise;
    logic       w_l_rise;
    logic       w_r_rise;
    logic       w_u_rise;

    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_start (
        .clk(clk), .rst(rst), .i_tick(tick), .i_clr(w_switch), .i_din(w_start_raw),
        .o_level(w_levels_unused[3]), .o_rise(w_start_rise)
    );
    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_l (
        .clk(clk), .rst(rst), .i_tick(tick), .i_clr(w_switch), .i_din(w_l_raw),
        .o_level(w_levels_unused[2]), .o_rise(w_l_rise)
    );
    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_r (
        .clk(clk), .rst(rst), .i_tick(tick), .i_clr(w_switch), .i_din(w_r_raw),
        .o_level(w_levels_unused[1]), .o_rise(w_r_rise)
    );
    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_u (
        .clk(clk), .rst(rst), .i_tick(tick), .i_clr(w_switch), .i_din(w_u_raw),
        .o_level(w_levels_unused[0]), .o_rise(w_u_rise)
    );

    turn_state_e   r_state;
    turn_state_e   w_state_nxt;
    logic [2:0]    r_req;
    logic [2:0]    w_req_nxt;
    logic [2:0]    w_new_req;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          r_start_pulse;

    // r_req is one-hot {l, r, u}; a fresh edge outranks consume and expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_hold_nxt  = r_hold;
        w_new_req   = w_l_rise ? 3'b100 : w_r_rise ? 3'b010 : w_u_rise ? 3'b001 : 3'b000;
        if (w_switch) begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 3'b000;
            w_hold_nxt  = '0;
        end else if (w_new_req != 3'b000) begin
            w_state_nxt = ST_PEND;
            w_req_nxt   = w_new_req;
            w_hold_nxt  = HOLD_LOAD;
        end else if (r_state == ST_PEND) begin
            if (consume || (tick && (r_hold <= HW'(1)))) begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 3'b000;
                w_hold_nxt  = '0;
            end else if (tick) begin
                w_hold_nxt = r_hold - HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_req         <= 3'b000;
            r_hold        <= '0;
            r_start_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_req         <= w_req_nxt;
            r_hold        <= w_hold_nxt;
            r_start_pulse <= w_start_rise;
        end
    end

    assign start_pulse = r_start_pulse;
    assign lturn       = r_req[2];
    assign rturn       = r_req[1];
    assign uturn       = r_req[0];
    assign req_valid   = |r_req;

endmodule
